// File: rtl/flash_cache_controller.sv
// Single-line read cache in front of a QSPI flash reader: word hits are answered next cycle,
// misses fetch the whole line with one command and chained data requests.
module flash_cache_controller #(
  parameter int LINE_WORDS_LOG2 = 4,
  parameter int ADDR_WIDTH      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_address,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  input  logic                  flush,
  output logic                  qspi_enable,
  output logic [23:0]           qspi_address,
  output logic                  qspi_changeAddress,
  output logic                  qspi_requestData,
  input  logic [31:0]           qspi_readData,
  input  logic                  qspi_readDataValid,
  input  logic                  qspi_initialised,
  input  logic                  qspi_busy
);
  localparam int L     = LINE_WORDS_LOG2;
  localparam int WORDS = 1 << L;
  localparam int TAG_W = ADDR_WIDTH - 2 - L;
  localparam logic [L:0] LAST_PTR = (L + 1)'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQUEST, FILL} state_t;

  state_t               state_q;
  logic [TAG_W-1:0]     tag_q, pend_tag_q;
  logic [L-1:0]         pend_idx_q;
  logic                 pend_q, line_valid_q, flush_pend_q, enable_q, chg_q;
  logic                 resp_valid_q;
  logic [31:0]          resp_data_q;
  logic [WORDS-1:0]     word_vld_q;
  logic [L:0]           ptr_q;
  logic [31:0]          mem_q [WORDS];

  logic [TAG_W-1:0]     req_tag;
  logic [L-1:0]         req_idx, fill_idx;
  logic                 accept, req_hit, fill_wr, last_wr, req_fwd, pend_fwd, start;
  logic [ADDR_WIDTH-1:0] line_base;
  logic                 unused_addr_bits;

  assign req_tag   = req_address[ADDR_WIDTH-1:2+L];
  assign req_idx   = req_address[1+L:2];
  assign fill_idx  = ptr_q[L-1:0];
  assign unused_addr_bits = ^req_address[1:0];

  assign req_ready = qspi_initialised && enable_q && !pend_q;
  assign accept    = req_valid && req_ready;
  assign req_hit   = line_valid_q && (req_tag == tag_q) && word_vld_q[req_idx];
  assign fill_wr   = (state_q == FILL) && qspi_readDataValid;
  assign last_wr   = fill_wr && (ptr_q == LAST_PTR);
  // A word landing in the same cycle it is requested is forwarded straight from the device.
  assign req_fwd   = fill_wr && (req_tag == tag_q) && (req_idx == fill_idx);
  assign pend_fwd  = pend_q && fill_wr && (pend_tag_q == tag_q) && (pend_idx_q == fill_idx);
  assign start     = (state_q == IDLE) && pend_q && !qspi_busy &&
                     (!line_valid_q || (pend_tag_q != tag_q));

  assign line_base          = {tag_q, {(L + 2){1'b0}}};
  assign qspi_address       = 24'(line_base);
  assign qspi_enable        = enable_q;
  assign qspi_changeAddress = chg_q;
  // Held through the address phase so the device chains straight into the first word.
  assign qspi_requestData   = (state_q == REQUEST) || ((state_q == FILL) && !last_wr);
  assign resp_valid         = resp_valid_q;
  assign resp_data          = resp_data_q;

  always_ff @(posedge clk) begin
    if (fill_wr) mem_q[fill_idx] <= qspi_readData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      pend_tag_q   <= '0;
      pend_idx_q   <= '0;
      pend_q       <= 1'b0;
      line_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      enable_q     <= 1'b0;
      chg_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      word_vld_q   <= '0;
      ptr_q        <= '0;
    end else begin
      enable_q     <= 1'b1;
      chg_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      if (accept && (req_hit || req_fwd)) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= req_hit ? mem_q[req_idx] : qspi_readData;
      end else if (accept) begin
        pend_q     <= 1'b1;
        pend_tag_q <= req_tag;
        pend_idx_q <= req_idx;
      end
      if (pend_fwd) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= qspi_readData;
        pend_q       <= 1'b0;
      end
      if (fill_wr) begin
        word_vld_q[fill_idx] <= 1'b1;
        ptr_q                <= ptr_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= REQUEST;
            tag_q        <= pend_tag_q;
            line_valid_q <= 1'b1;
            word_vld_q   <= '0;
            ptr_q        <= '0;
            chg_q        <= 1'b1;
          end else if (flush) begin
            line_valid_q <= 1'b0;
          end
        end
        REQUEST: begin
          state_q      <= FILL;
          flush_pend_q <= flush_pend_q | flush;
        end
        FILL: begin
          // A flush seen mid-fill lets the fill finish, then drops the line.
          if (last_wr) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            if (flush_pend_q || flush) line_valid_q <= 1'b0;
          end else if (flush) begin
            flush_pend_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
